// File: rtl/pmod_vector_tx_if.sv
// Control and PMOD-side signal bundle for the vector transmitter.
// The master side (button logic or bench) drives start/loop/abort; the slave (transmitter) drives the pins.
interface pmod_vector_tx_if;
  logic       start;
  logic       loop;
  logic       abort;
  logic [3:0] vec;
  logic       strobe;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output loop,
    output abort,
    input  vec,
    input  strobe,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  loop,
    input  abort,
    output vec,
    output strobe,
    output busy,
    output done
  );
endinterface

// File: rtl/pmod_vector_tx.sv
// Steps a 4-bit vector through all 16 values on the PMOD header, one vector every STEP_CYCLES,
// with a registered sample strobe that sits strictly inside each vector's stable window.
module pmod_vector_tx #(
  parameter int STEP_CYCLES   = 12000000,
  parameter int SETTLE_CYCLES = 1200,
  parameter int STROBE_CYCLES = 1200
) (
  input  logic             clk,
  input  logic             rst,
  pmod_vector_tx_if.slave  bus
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(SETTLE_CYCLES + STROBE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_vec;
  logic          r_strobe;
  logic          r_busy;
  logic          r_done;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync2_d;
  logic          w_start_rise;

  // Start button synchronizer plus delayed copy of the second flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= bus.start;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign w_start_rise = r_sync2 & ~r_sync2_d;

  // Sweep FSM: owns the cycle counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= CNT_ZERO;
      r_vec    <= 4'd0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if ((r_state != IDLE) && bus.abort) begin
      // Abort outranks the wrap decision, so a sweep ending here never reports done.
      r_state  <= IDLE;
      r_cnt    <= CNT_ZERO;
      r_vec    <= 4'd0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_strobe <= 1'b0;
          if (w_start_rise && !bus.abort) begin
            r_state <= SETTLE;
            r_cnt   <= CNT_ZERO;
            r_vec   <= 4'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == SETTLE_LAST) begin
            r_state  <= STROBE;
            r_strobe <= 1'b1;
          end else begin
            r_strobe <= 1'b0;
          end
        end
        STROBE: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == STROBE_LAST) begin
            r_state  <= HOLD;
            r_strobe <= 1'b0;
          end else begin
            r_strobe <= 1'b1;
          end
        end
        HOLD: begin
          r_strobe <= 1'b0;
          if (r_cnt == STEP_LAST) begin
            r_cnt <= CNT_ZERO;
            if (r_vec != 4'd15) begin
              r_vec   <= r_vec + 4'd1;
              r_state <= SETTLE;
            end else if (bus.loop) begin
              r_vec   <= 4'd0;
              r_state <= SETTLE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= CNT_ZERO;
          r_vec    <= 4'd0;
          r_strobe <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec    = r_vec;
  assign bus.strobe = r_strobe;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
